mc_main_control: RTL and testbench

// - Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode, sequences each

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mc_ctrl_decode.sv | 72 +++++++
 rtl/mc_main_control.sv | 99 +++++++++
 tb/tb_mc_main_control.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path.
// Covers opcodes, ALUOp codes, mux selects, FSM states and the control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic SRCA_PC   = 1'b0;
  localparam logic SRCA_REGA = 1'b1;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode of the main FSM state.
// Only FETCH (mem_ready) and BRANCH (zero) look at anything besides the state.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_en     = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: ctrl_o.iord = 1'b1;
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      // The write strobe stays up for the whole stall, including the completing cycle.
      S_MEMWR: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_REGB;
        ctrl_o.alu_op    = ALUOP_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        ctrl_o.pc_en     = zero_i;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = SRCA_REGA;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADDI;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_en  = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Main control FSM of the multicycle MIPS datapath: state/opcode registers and sequencing.
// Output decode lives in mc_ctrl_decode.
module mc_main_control
  import mips_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op
);

  state_t     state_q, state_d;
  state_t     decodeState;
  logic [5:0] op_q, op_d;
  logic       memRdy;
  logic       illegal;
  ctrl_t      ctrl;

  assign memRdy = USE_MEM_READY ? mem_ready : 1'b1;

  // While reset is held the outputs look like FETCH, whatever the old state was.
  assign decodeState = reset ? S_FETCH : state_q;

  mc_ctrl_decode u_decode (
    .state_i     (decodeState),
    .mem_ready_i (memRdy),
    .zero_i      (zero),
    .ctrl_o      (ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    op_d    = op_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH:  state_d = memRdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      // op_q, not the live IR field, picks load versus store.
      S_MEMADR:  state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = memRdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = memRdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign pc_en      = ctrl.pc_en & ~reset;
  assign ir_write   = ctrl.ir_write & ~reset;
  assign illegal_op = illegal & ~reset;
  assign iord       = ctrl.iord;
  assign mem_write  = ctrl.mem_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: directed literal checks plus random instruction streams,
// all compared every cycle against an instruction-level reference model.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       illegal_op;

  mc_main_control #(.USE_MEM_READY(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       illegal_op;
  } outs_t;

  localparam int K_LW = 1, K_SW = 2, K_R = 3, K_ADDI = 4, K_BEQ = 5, K_J = 6;
  localparam int P_ADR = 0, P_RD = 1, P_MWB = 2, P_WR = 3, P_EX = 4, P_AWB = 5;
  localparam int P_BR = 6, P_AIEX = 7, P_AIWB = 8, P_JMP = 9;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  // Model position: phase 0 = fetch, 1 = decode, 2.. = the instruction's body steps.
  int mdlKind = 0;
  int mdlPhase = 0;

  function automatic int kindOf(input logic [5:0] op);
    case (op)
      6'h23:   return K_LW;
      6'h2b:   return K_SW;
      6'h00:   return K_R;
      6'h08:   return K_ADDI;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return 0;
    endcase
  endfunction

  // Body steps of each instruction after decode; -1 marks the end of the list.
  function automatic int bodyPhase(input int kind, input int idx);
    case (kind)
      K_LW:   case (idx) 0: return P_ADR; 1: return P_RD; 2: return P_MWB; default: return -1; endcase
      K_SW:   case (idx) 0: return P_ADR; 1: return P_WR; default: return -1; endcase
      K_R:    case (idx) 0: return P_EX;  1: return P_AWB; default: return -1; endcase
      K_ADDI: case (idx) 0: return P_AIEX; 1: return P_AIWB; default: return -1; endcase
      K_BEQ:  case (idx) 0: return P_BR;  default: return -1; endcase
      K_J:    case (idx) 0: return P_JMP; default: return -1; endcase
      default: return -1;
    endcase
  endfunction

  function automatic outs_t expectOuts(input int kind, input int phase, input logic rst,
                                       input logic mr, input logic z, input logic [5:0] op);
    outs_t e;
    int    p;
    e = '0;
    if (rst) begin
      e.alu_src_b = 2'b01;
      return e;
    end
    if (phase == 0) begin
      e.alu_src_b = 2'b01;
      e.ir_write  = mr;
      e.pc_en     = mr;
      return e;
    end
    if (phase == 1) begin
      e.alu_src_b  = 2'b11;
      e.illegal_op = (kindOf(op) == 0);
      return e;
    end
    p = bodyPhase(kind, phase - 2);
    case (p)
      P_ADR:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      P_RD:   e.iord = 1'b1;
      P_MWB:  begin e.mem_to_reg = 1'b1; e.reg_write = 1'b1; end
      P_WR:   begin e.iord = 1'b1; e.mem_write = 1'b1; end
      P_EX:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
      P_AWB:  begin e.reg_dst = 1'b1; e.reg_write = 1'b1; end
      P_BR:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'b01; e.pc_en = z; end
      P_AIEX: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11; end
      P_AIWB: e.reg_write = 1'b1;
      P_JMP:  begin e.pc_src = 2'b10; e.pc_en = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic bit isMemPhase(input int kind, input int idx);
    return (bodyPhase(kind, idx) == P_RD) || (bodyPhase(kind, idx) == P_WR);
  endfunction

  // Advance the reference model at each rising edge from the inputs seen that cycle.
  always @(posedge clk) begin
    if (reset) begin
      mdlPhase <= 0;
      mdlKind  <= 0;
    end else if (mdlPhase == 0) begin
      mdlPhase <= mem_ready ? 1 : 0;
    end else if (mdlPhase == 1) begin
      if (kindOf(opcode) != 0) begin
        mdlKind  <= kindOf(opcode);
        mdlPhase <= 2;
      end else begin
        mdlPhase <= 0;
      end
    end else if (isMemPhase(mdlKind, mdlPhase - 2) && !mem_ready) begin
      mdlPhase <= mdlPhase;
    end else if (bodyPhase(mdlKind, mdlPhase - 1) < 0) begin
      mdlPhase <= 0;
    end else begin
      mdlPhase <= mdlPhase + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare the full control word against the model in the middle of every cycle.
  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    if (checkEn) begin
      e = expectOuts(mdlKind, mdlPhase, reset, mem_ready, zero, opcode);
      a = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_op, pc_src, illegal_op};
      checkOutput("model control word", 32'(a), 32'(e));
    end
  end

  task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic mr, input logic z);
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    zero      = z;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input logic [5:0] op);
    applyStimulus(1'b1, op, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, op, 1'b1, 1'b0);
  endtask

  initial begin
    int wrCount;
    int illCount;
    int wrAny;
    logic [5:0] opTab [6];
    logic [5:0] op;
    opTab = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h08, 6'h02};

    applyStimulus(1'b1, 6'h23, 1'b1, 1'b0);
    nextCycle();
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset ir_write", 32'(ir_write), 32'h0);
    checkOutput("reset pc_en", 32'(pc_en), 32'h0);
    checkOutput("reset alu_src_b", 32'(alu_src_b), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 6'h23, 1'b1, 1'b0);

    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("lw alu_op", 32'(alu_op), 32'h0);
      checkOutput("lw reg_write", 32'(reg_write), 32'(c == 5));
      checkOutput("lw mem_to_reg", 32'(mem_to_reg), 32'(c == 5));
      if (c == 4) checkOutput("lw memrd iord", 32'(iord), 32'h1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("lw back to fetch", 32'(ir_write), 32'h1);

    applyReset(6'h00);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checkOutput("rtype alu_op", 32'(alu_op), 32'h2);
        checkOutput("rtype alu_src_b", 32'(alu_src_b), 32'h0);
      end
      if (c == 4) begin
        checkOutput("rtype reg_dst", 32'(reg_dst), 32'h1);
        checkOutput("rtype reg_write", 32'(reg_write), 32'h1);
      end
      if (c == 5) checkOutput("rtype fetch at 5", 32'(ir_write), 32'h1);
      nextCycle();
    end

    for (int k = 0; k < 2; k++) begin
      applyReset(6'h04);
      zero = (k == 0);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        if (c == 3) begin
          checkOutput("beq pc_en", 32'(pc_en), 32'(k == 0));
          checkOutput("beq pc_src", 32'(pc_src), 32'h1);
          checkOutput("beq alu_op", 32'(alu_op), 32'h1);
        end
        nextCycle();
      end
    end

    applyReset(6'h2b);
    wrCount = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_ready = !(c >= 4 && c <= 6);
      @(negedge clk);
      if (mem_write) wrCount++;
      if (c == 8) checkOutput("sw fetch at 8", 32'(ir_write), 32'h1);
      nextCycle();
    end
    checkOutput("sw mem_write cycles", 32'(wrCount), 32'd4);

    applyReset(6'h3f);
    illCount = 0;
    wrAny = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (illegal_op) illCount++;
      if (reg_write || mem_write) wrAny++;
      if (c == 2) checkOutput("illegal pulse", 32'(illegal_op), 32'h1);
      if (c == 3) checkOutput("illegal then fetch", 32'(ir_write), 32'h1);
      nextCycle();
    end
    checkOutput("illegal pulse count", 32'(illCount), 32'd1);
    checkOutput("illegal no writes", 32'(wrAny), 32'd0);

    applyReset(6'h23);
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) reset = 1'b1;
      if (c == 5) begin
        reset  = 1'b0;
        opcode = 6'h08;
      end
      @(negedge clk);
      if (c == 4) begin
        checkOutput("reset in memrd reg_write", 32'(reg_write), 32'h0);
        checkOutput("reset in memrd iord", 32'(iord), 32'h0);
      end
      if (c == 5) begin
        checkOutput("after reset fetch", 32'(ir_write), 32'h1);
        checkOutput("after reset no wb", 32'(reg_write), 32'h0);
      end
      if (c == 7) begin
        checkOutput("addiex alu_op", 32'(alu_op), 32'h3);
        checkOutput("addiex alu_src_b", 32'(alu_src_b), 32'h2);
      end
      if (c == 8) begin
        checkOutput("addiwb reg_write", 32'(reg_write), 32'h1);
        checkOutput("addiwb reg_dst", 32'(reg_dst), 32'h0);
      end
      nextCycle();
    end

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = opTab[$urandom_range(0, 5)];
      applyStimulus($urandom_range(0, 99) == 0, op, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) == 1);
      nextCycle();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
